// File: rtl/nibble_serial_adder.sv
// Wide adder that walks an N-nibble operand pair through a single 4-bit
// ripple-carry slice, LSB nibble first, with the inter-nibble carry registered.

module nibble_add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c3,
  output logic       o_c4
);
  logic [4:0] w_c;

  assign w_c[0] = i_c;
  for (genvar g = 0; g < 4; g++) begin : g_bit
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end
  // Carry into bit 3 is needed for signed overflow of the top nibble.
  assign o_c3 = w_c[3];
  assign o_c4 = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [NIBBLES-1:0][3:0]  r_a, r_b, r_wsum, w_wsum_nx;
  logic [IW-1:0]            r_idx;
  logic                     r_carry;
  logic [4*NIBBLES-1:0]     r_sum;
  logic                     r_cout, r_ovf;
  logic [3:0]               w_s4;
  logic                     w_c3, w_c4;
  logic                     w_last, w_accept;

  nibble_add4 u_slice (
    .i_a  (r_a[r_idx]),
    .i_b  (r_b[r_idx]),
    .i_c  (r_carry),
    .o_s  (w_s4),
    .o_c3 (w_c3),
    .o_c4 (w_c4)
  );

  assign w_last   = (r_idx == IW'(NIBBLES - 1));
  assign w_accept = start && (r_state != S_ADD);

  always_comb begin
    w_wsum_nx        = r_wsum;
    w_wsum_nx[r_idx] = w_s4;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_ADD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_wsum  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_wsum  <= '0;
    end else if (r_state == S_ADD) begin
      r_wsum  <= w_wsum_nx;
      r_carry <= w_c4;
      r_idx   <= r_idx + IW'(1);
      // Final nibble: publish the merged sum, not the stale working copy.
      if (w_last) begin
        r_sum  <= w_wsum_nx;
        r_cout <= w_c4;
        r_ovf  <= w_c3 ^ w_c4;
      end
    end
  end

  assign busy = (r_state == S_ADD);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// additions compared with an arithmetic reference model.

module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int n_chk = 0;
  int n_err = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic; overflow from operand/result signs.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_sum(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from an idle or done cycle; ends in the done cycle.
  task automatic run_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_sum(x, y, c);
    a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, "_busy0"}, busy, 1'b1);
    for (int k = 1; k < N; k++) begin
      tick();
      chk({tag, "_busyk"}, {busy, done}, 2'b10);
    end
    tick();
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_sum"}, sum, r[W-1:0]);
    chk({tag, "_cout"}, cout, r[W]);
    chk({tag, "_ovf"}, ovf, ref_ovf(x, y, c));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [W-1:0] dsum[$];
    logic         dcout[$];
    logic         dovf[$];
    int           dcyc[$];
    logic [W:0]   r;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) tick();
    chk("rst_state", {busy, done, cout, ovf}, 4'b0000);
    chk("rst_sum", sum, 16'h0000);
    rst = 1'b0;
    tick();

    run_add("t1", 16'h5555, 16'h3333, 1'b0);
    chk("t1_abs", {sum, cout, ovf}, {16'h8888, 2'b01});
    tick();
    chk("t1_hold", {busy, done, sum, cout, ovf}, {2'b00, 16'h8888, 2'b01});

    run_add("t2", 16'hFFFF, 16'h0001, 1'b0);
    chk("t2_abs", {sum, cout, ovf}, {16'h0000, 2'b10});
    run_add("t3a", 16'h8000, 16'h7FFF, 1'b1);
    run_add("t3b", 16'h0000, 16'h0000, 1'b1);
    chk("t3b_abs", {sum, cout, ovf}, {16'h0001, 2'b00});
    tick();

    // Start during ADD must be ignored.
    a = 16'h000A; b = 16'h000C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b1; a = 16'h1111; b = 16'h1111;
    cnt = 0; dsum.delete();
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
      if (done) begin cnt++; dsum.push_back(sum); dcyc.push_back(k); end
    end
    chk("ign_cnt", cnt, 1);
    if (cnt == 1) begin
      chk("ign_sum", dsum[0], 16'h0016);
      chk("ign_lat", dcyc[0], N);
    end
    chk("ign_cout", cout, 1'b0);

    // Back-to-back with start held through DONE.
    dsum.delete(); dcyc.delete();
    a = 16'hA000; b = 16'hC000; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h0001; b = 16'h0001;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == N + 1) start = 1'b0;
      if (done) begin
        dsum.push_back(sum); dcout.push_back(cout); dovf.push_back(ovf); dcyc.push_back(k);
      end
    end
    chk("b2b_cnt", dsum.size(), 2);
    if (dsum.size() == 2) begin
      chk("b2b_r0", {dsum[0], dcout[0], dovf[0]}, {16'h6000, 2'b11});
      chk("b2b_r1", {dsum[1], dcout[1], dovf[1]}, {16'h0002, 2'b00});
      chk("b2b_gap", dcyc[1] - dcyc[0], N + 1);
    end

    // Reset during the second ADD cycle aborts silently.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out", {busy, done, sum, cout, ovf}, 20'h0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) cnt++;
    end
    chk("mrst_nodone", cnt, 0);
    run_add("mrst_fresh", 16'h1234, 16'h4321, 1'b0);
    chk("mrst_abs", sum, 16'h5555);

    // Start coinciding with reset is dropped.
    tick();
    start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_start", {busy, done}, 2'b00);
    tick();
    chk("rst_start2", {busy, done}, 2'b00);

    // Random additions, chained back-to-back from the done cycle.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      logic c;
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      if (i % 7 == 0) x = '1;
      if (i % 5 == 0) tick();
      run_add("rnd", x, y, c);
    end
    r = ref_sum(16'h7FFF, 16'h0000, 1'b1);
    run_add("edge_pos", 16'h7FFF, 16'h0000, 1'b1);
    chk("edge_pos_abs", {sum, cout, ovf}, {r[W-1:0], 2'b01});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that sequences an N-nibble operand pair through one 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
- Registers the carry between nibbles and assembles the full-width sum.
- Sits directly upstream of the 4-bit adder and wraps it. It feeds nibble operands and carry-in into the slice and consumes the slice's sum and carry-out.
- Gives wide additions without a wide combinational carry chain.

Parameters:
- NIBBLES, default 4: operand width in nibbles (W = 4*NIBBLES bits); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled on rising edge of clk
- a  input  W  operand A; sampled only on an accepted start
- b  input  W  operand B; sampled only on an accepted start
- cin  input  1  carry-in to nibble 0; sampled only on an accepted start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; sum/cout/ovf just updated
- sum  output  W  result of the last completed addition
- cout  output  1  carry out of the MSB nibble
- ovf  output  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high.
  - rst has priority over all other inputs.
  - Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, nibble index=0, carry reg=0, working regs=0.
- State machine:
  - States are IDLE, ADD and DONE.
  - IDLE: busy=0. start=1 latches a, b and cin into working regs, clears the index and moves to ADD.
  - ADD: busy=1. Each edge:
    - Slice computes {c4, s4} = a_nib[idx] + b_nib[idx] + carry.
    - s4 is written into working-sum nibble idx; carry <= c4; idx increments.
  - ADD to DONE: on the edge that processes idx = NIBBLES-1, the block:
    - copies the working sum to sum
    - sets cout = c4
    - sets ovf = (carry into bit W-1) XOR c4, taken from inside the top nibble
    - asserts done, and goes to DONE.
  - DONE: busy=0, done=1 for this single cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back) and moves to ADD.
    - Otherwise the next state is IDLE.
- Latency:
  - Start is sampled at edge 0; nibble k is processed at edge k+1.
  - done is high during the cycle after edge NIBBLES, i.e. NIBBLES clocks after acceptance.
  - Throughput is one addition per NIBBLES+1 clocks. Back-to-back accepts give NIBBLES+1 clocks between done pulses.
- Start while busy: start in ADD is ignored. It is not queued, and the latched operands are not disturbed.
- Operand stability: a, b and cin may change freely after the accept edge.
- Output holding:
  - sum/cout/ovf change only on a completion edge (or reset).
  - They hold their values through IDLE and through a subsequent ADD until the next completion.
- Arithmetic:
  - Unsigned: {cout, sum} = a + b + cin, modulo 2^(W+1).
  - No saturation. Wrap-around is reported via cout and ovf only.
- Reset mid-operation: at any state, rst returns to IDLE with all outputs zero.
  - No done pulse is produced for the aborted addition.
  - A start coinciding with rst is ignored.

Test Plan (NIBBLES=4):
- a=0x5555, b=0x3333, cin=0, single start → done exactly 4 clocks after accept; sum=0x8888, cout=0, ovf=1; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; carry ripples through all nibbles.
- a=0x8000, b=0x7FFF, cin=1 → sum=0x0000, cout=1, ovf=0. Then a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0, ovf=0.
- Start 0x000A+0x000C; pulse start again with a=0x1111 during ADD → second start ignored; result sum=0x0016, cout=0; only one done pulse.
- Back-to-back: start held high through the DONE cycle with 0xA000+0xC000 then 0x0001+0x0001 → sum=0x6000, cout=1, ovf=1; then sum=0x0002, cout=0, ovf=0; done pulses 5 clocks apart.
- Assert rst for one cycle at the 2nd ADD cycle of 0x1234+0x4321 → next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows; a fresh start afterwards yields 0x5555.
